// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle single-precision adder: a combinational preadder aligns the operands,
// then a state machine walks add, normalize, round and pack, one stage per cycle.

module fp_preadd (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_sign,
  output logic [7:0]  o_exp,
  output logic [27:0] o_mant_great,
  output logic [27:0] o_mant_small,
  output logic        o_special,
  output logic [31:0] o_special_res
);
  logic        w_a_ge;
  logic [31:0] w_g;
  logic [30:0] w_s;
  logic [7:0]  w_exp_s;
  logic [7:0]  w_diff;
  logic [27:0] w_mant_s;
  logic [27:0] w_mask;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  assign w_a_ge   = (i_a[30:0] >= i_b[30:0]);
  assign w_g      = w_a_ge ? i_a : i_b;
  assign w_s      = w_a_ge ? i_b[30:0] : i_a[30:0];

  // Denormals take the minimum exponent with a clear hidden bit.
  assign o_exp        = (w_g[30:23] == 8'd0) ? 8'd1 : w_g[30:23];
  assign w_exp_s      = (w_s[30:23] == 8'd0) ? 8'd1 : w_s[30:23];
  assign o_sign       = w_g[31];
  assign o_mant_great = {1'b0, (w_g[30:23] != 8'd0), w_g[22:0], 3'b000};
  assign w_mant_s     = {1'b0, (w_s[30:23] != 8'd0), w_s[22:0], 3'b000};
  assign w_diff       = o_exp - w_exp_s;
  assign w_mask       = ~({28{1'b1}} << w_diff);

  always_comb begin
    o_mant_small = 28'd0;
    if (w_diff >= 8'd27) begin
      o_mant_small = {27'd0, |w_mant_s};
    end else begin
      o_mant_small = (w_mant_s >> w_diff) | {27'd0, |(w_mant_s & w_mask)};
    end
  end

  assign w_a_nan   = (&i_a[30:23]) & (|i_a[22:0]);
  assign w_b_nan   = (&i_b[30:23]) & (|i_b[22:0]);
  assign w_a_inf   = (&i_a[30:23]) & ~(|i_a[22:0]);
  assign w_b_inf   = (&i_b[30:23]) & ~(|i_b[22:0]);
  assign o_special = (&i_a[30:23]) | (&i_b[30:23]);

  always_comb begin
    o_special_res = i_b;
    if (w_a_nan) begin
      o_special_res = i_a | 32'h0040_0000;
    end else if (w_b_nan) begin
      o_special_res = i_b | 32'h0040_0000;
    end else if (w_a_inf && w_b_inf && (i_a[31] ^ i_b[31])) begin
      o_special_res = 32'h7FC0_0000;
    end else if (w_a_inf) begin
      o_special_res = i_a;
    end
  end
endmodule

module fp_add_seq_ctrl #(
  parameter bit BYPASS_SPECIAL = 1'b1,
  parameter int CYC_W          = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      number_A,
  input  logic [31:0]      number_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             busy,
  output logic [CYC_W-1:0] last_cycles
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ADD, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [31:0]       r_a, r_b;
  logic              r_eff_sub;
  logic              r_sign;
  logic [9:0]        r_exp;
  logic [27:0]       r_great, r_small, r_sum;
  logic              r_special;
  logic [31:0]       r_spec_res;
  logic [31:0]       r_result;
  logic [CYC_W-1:0]  r_cyc, r_last;

  logic              w_sign, w_special;
  logic [7:0]        w_exp;
  logic [27:0]       w_great, w_small;
  logic [31:0]       w_spec_res;
  logic              w_inc;
  logic [24:0]       w_rnd;
  logic [27:0]       w_rsum;
  logic [31:0]       w_packed;

  fp_preadd u_preadd (
    .i_a           (r_a),
    .i_b           (r_b),
    .o_sign        (w_sign),
    .o_exp         (w_exp),
    .o_mant_great  (w_great),
    .o_mant_small  (w_small),
    .o_special     (w_special),
    .o_special_res (w_spec_res)
  );

  // Nearest-even: round up above half, or at exactly half when the LSB is odd.
  assign w_inc  = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
  assign w_rnd  = r_sum[27:3] + {24'd0, w_inc};
  assign w_rsum = {w_rnd, 3'b000};

  assign w_packed = (r_exp >= 10'd255) ? {r_sign, 8'hFF, 23'd0}
                  : {r_sign, (r_sum[26] ? r_exp[7:0] : 8'd0), r_sum[25:3]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_LOAD;
      S_LOAD:  w_next = (w_special && BYPASS_SPECIAL) ? S_DONE : S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM: begin
        if (r_sum[27])                           w_next = S_ROUND;
        else if (r_sum == 28'd0)                 w_next = S_DONE;
        else if (!r_sum[26] && r_exp > 10'd1)    w_next = S_NORM;
        else                                     w_next = S_ROUND;
      end
      S_ROUND: w_next = S_PACK;
      S_PACK:  w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_eff_sub  <= 1'b0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_great    <= '0;
      r_small    <= '0;
      r_sum      <= '0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_result   <= '0;
      r_cyc      <= '0;
      r_last     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a       <= number_A;
          r_b       <= number_B;
          r_eff_sub <= number_A[31] ^ number_B[31];
          r_cyc     <= '0;
        end
        S_LOAD: begin
          r_sign     <= w_sign;
          r_exp      <= {2'b00, w_exp};
          r_great    <= w_great;
          r_small    <= w_small;
          r_special  <= w_special;
          r_spec_res <= w_spec_res;
          if (w_special && BYPASS_SPECIAL) r_result <= w_spec_res;
        end
        S_ADD: r_sum <= r_eff_sub ? (r_great - r_small) : (r_great + r_small);
        S_NORM: begin
          if (r_sum[27]) begin
            r_sum <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + 10'd1;
          end else if (r_sum == 28'd0) begin
            r_result <= r_special ? r_spec_res : 32'd0;
          end else if (!r_sum[26] && r_exp > 10'd1) begin
            r_sum <= {r_sum[26:0], 1'b0};
            r_exp <= r_exp - 10'd1;
          end
        end
        S_ROUND: begin
          if (w_rsum[27]) begin
            r_sum <= {1'b0, w_rsum[27:1]};
            r_exp <= r_exp + 10'd1;
          end else begin
            r_sum <= w_rsum;
          end
        end
        S_PACK: r_result <= r_special ? r_spec_res : w_packed;
        S_DONE: if (out_ready) r_last <= r_cyc;
        default: ;
      endcase
      if (r_state != S_IDLE && r_state != S_DONE && r_cyc != {CYC_W{1'b1}})
        r_cyc <= r_cyc + 1'b1;
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign last_cycles = r_last;
endmodule
